seq_addsub: RTL
===============

# seq_addsub

Parametrised multi-cycle adder/subtractor for the multi-cycle CPU datapath. It processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry through a register between chunks. The execute stage can therefore trade latency for a shorter critical path. It supports subtract-with-carry for multi-word arithmetic and reports carry, signed overflow and zero flags. It uses a start/busy/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits
- CHUNK, 8, bits processed per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails; NCHUNK = WIDTH/CHUNK
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only while idle
- op_sub  input  1  0 = add, 1 = subtract
- operand1  input  WIDTH  operand A
- operand2  input  WIDTH  operand B
- cin  input  1  carry in (add) / not-borrow in (sub)
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  registered result
- cout  output  1  carry out of bit WIDTH-1
- overflow_flag  output  1  signed overflow
- zero_flag  output  1  result == 0

## Operation
- Effective operand B: eb = op_sub ? ~operand2 : operand2. The block computes {cout, result} = operand1 + eb + cin.
  - Plain subtract uses cin=1.
  - A subtract with cin=0 yields A-B-1, so cout=0 means a borrow occurred.
- States: IDLE, RUN.
  - IDLE: busy=0. On start=1:
    - latch operand1, eb, cin and op_sub into internal registers
    - clear chunk counter k
    - go to RUN.
  - RUN: busy=1. Each edge:
    - compute {c, s} = a[k*CHUNK +: CHUNK] + eb[k*CHUNK +: CHUNK] + carry
    - store s into the internal sum register at chunk k
    - carry <= c
    - k <= k+1.
  - On the edge that processes chunk NCHUNK-1:
    - load result, cout, overflow_flag and zero_flag from the completed sum
    - assert done
    - return to IDLE.
- overflow_flag = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. This equals: operand1 and eb have the same sign and the result sign differs.
- zero_flag = (result == 0), computed from the full final sum.
- result and the flags update only at completion. Between operations and during RUN they hold the previous operation's values.
- start while busy=1 is ignored. Operand inputs are don't-care after the start edge.
- Reset (asserted at any time, including mid-RUN):
  - state IDLE, k=0, internal registers 0
  - busy=0, done=0, result=0, cout=0, overflow_flag=0, zero_flag=0
  - an aborted operation produces no done.
- CHUNK=WIDTH is legal: RUN lasts one cycle.

## Timing
- Start accepted at edge T (IDLE, start=1): busy=1 from after edge T.
- Chunks are processed at edges T+1 … T+NCHUNK.
- At edge T+NCHUNK:
  - result and flags become valid
  - done=1 and busy=0 for the cycle T+NCHUNK … T+NCHUNK+1
  - done clears at edge T+NCHUNK+1.
- Latency from start edge to done: NCHUNK cycles. With defaults this is 4.
- Back-to-back: start=1 during the done cycle is accepted at edge T+NCHUNK+1. Throughput is one operation per NCHUNK+1 cycles.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=32, CHUNK=8: add 0x7FFFFFFF + 0x00000001, cin=0.
  - Required: done exactly 4 cycles after the start edge, result=0x80000000, cout=0, overflow_flag=1, zero_flag=0.
- Add 0xFFFFFFFF + 0x00000001, cin=0, which ripples the carry through all 4 chunks.
  - Required: result=0x00000000, cout=1, overflow_flag=0, zero_flag=1.
- Subtract, cin=1:
  - 5 - 7 → result=0xFFFFFFFE, cout=0, overflow_flag=0.
  - 0x80000000 - 1 → result=0x7FFFFFFF, cout=1, overflow_flag=1.
  - 9 - 9 with cin=0 → result=0xFFFFFFFF, cout=0.
- Start 1+2, then pulse start with 100+200 at cycles +1 and +2.
  - Required: the pulses are ignored; one done with result=3.
  - Start 10+20 during that done cycle → done 5 cycles after the first done, result=30.
  - result holds 3 until the second done.
- Mid-operation reset: assert rst asynchronously 2 cycles after start (between edges).
  - Required: busy, done, result and all flags 0 immediately; no done follows.
  - A following add 0x12345678 + 0x11111111 gives 0x23456789.
- Random regression: 1000 random operand1, operand2, op_sub and cin values in each of three builds: CHUNK=8, CHUNK=32 (latency 1) and CHUNK=1 (latency 32).
  - Required: every result, cout, overflow_flag and zero_flag matches a WIDTH+1-bit reference model.
  - Latency equals NCHUNK in every build.

Source files
------------

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle chunked adder/subtractor with carry, overflow and zero flags
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow_flag,
    output logic             zero_flag
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0]    K_LAST     = KW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("seq_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] eb_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] sum_full;
    logic             msb_cin;

    // Shifts instead of variable part-selects keep CHUNK == WIDTH and CHUNK == 1 on the same path.
    always_comb begin
        base     = 32'(k) * 32'(CHUNK);
        a_chunk  = CHUNK'(a_reg >> base);
        b_chunk  = CHUNK'(eb_reg >> base);
        {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry);
        sum_full = (sum_reg & ~(CHUNK_MASK << base)) | (WIDTH'(chunk_sum) << base);
        // Carry into the sign bit recovered from the sign-bit sum itself.
        msb_cin  = a_reg[WIDTH-1] ^ eb_reg[WIDTH-1] ^ sum_full[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            k             <= '0;
            a_reg         <= '0;
            eb_reg        <= '0;
            sum_reg       <= '0;
            carry         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            cout          <= 1'b0;
            overflow_flag <= 1'b0;
            zero_flag     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg   <= operand1;
                        eb_reg  <= op_sub ? ~operand2 : operand2;
                        carry   <= cin;
                        k       <= '0;
                        sum_reg <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_reg <= sum_full;
                    carry   <= chunk_cout;
                    k       <= k + 1'b1;
                    if (k == K_LAST) begin
                        result        <= sum_full;
                        cout          <= chunk_cout;
                        overflow_flag <= msb_cin ^ chunk_cout;
                        zero_flag     <= (sum_full == '0);
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        k             <= '0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
